// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: core-side request/response
// structs, controller state encoding and the byte-lane mask helper.
package data_mem_ctrl_pkg;

    localparam int cnt_width_c = 4;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    // Byte stores touch one lane; word stores ignore the low address bits.
    function automatic logic [3:0] lane_mask(input logic byte_not_word, input logic [1:0] lane);
        return byte_not_word ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Word-organised storage: one combinational read port and one synchronous
// write port with per-byte-lane enables.
module dmem_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic [addr_width_p-1:0] waddr,
    input  logic [3:0]              wmask,
    input  logic [31:0]             wdata,
    input  logic [addr_width_p-1:0] raddr,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**addr_width_p];

    // NOTE: storage has no reset; clearing every word would turn the array into
    // flops and buys nothing, since software never reads before writing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency data-memory controller: accepts one request in IDLE, waits
// latency_p cycles, then holds the response until the core acknowledges it.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o,
    output logic        busy_o
);

    dmem_state_e             state_q, state_d;
    logic [cnt_width_c-1:0]  cnt_q, cnt_d;
    logic [31:0]             resp_q, resp_d;

    logic                    accept;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [3:0]              wmask;
    logic [31:0]             wdata;
    logic [31:0]             rdata;
    logic [31:0]             load_data;
    logic                    unused_addr;

    assign unused_addr = ^addr_i[31:2+addr_width_p];

    assign accept   = reset && (state_q == IDLE) && to_mem_i.valid;
    assign word_idx = addr_i[2 +: addr_width_p];
    assign lane     = addr_i[1:0];
    assign wmask    = (accept && to_mem_i.wen) ? lane_mask(to_mem_i.byte_not_word, lane) : 4'b0000;
    assign wdata    = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}} : to_mem_i.write_data;

    dmem_array #(.addr_width_p(addr_width_p)) u_array (
        .clk   (clk),
        .waddr (word_idx),
        .wmask (wmask),
        .wdata (wdata),
        .raddr (word_idx),
        .rdata (rdata)
    );

    // Read happens before the write lands, so loads see the pre-edge word.
    assign load_data = to_mem_i.byte_not_word ? {24'b0, rdata[8*lane +: 8]} : rdata;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    resp_d = to_mem_i.wen ? 32'b0 : load_data;
                    if (latency_p == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = cnt_width_c'(latency_p - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                if (to_mem_i.yumi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    assign from_mem_o.valid     = (state_q == RESP);
    assign from_mem_o.read_data = (state_q == RESP) ? resp_q : 32'b0;
    assign from_mem_o.yumi      = accept;
    assign busy_o               = (state_q != IDLE);

endmodule
